ram_fifo_ctrl: RTL and testbench

Byte FIFO controller that turns the single-port 32 x 8 RAM into a valid/ready streaming FIFO. It sits directly upstream of the RAM, driving its address, write-enable and write-data pins and consuming its read-data pin. It arbitrates pushes and pops onto the one RAM port and holds the head byte in an output register. The RAM has a registered read address: data appears on its read pin in the cycle after a read address is presented with write-enable low.

---
 rtl/ram_fifo_ctrl_if.sv | 22 ++
 rtl/ram_fifo_ctrl.sv | 79 +++++++
 tb/tb_ram_fifo_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_if.sv
// Streaming side of the RAM-backed byte FIFO: push/pop handshakes plus occupancy status.
interface ram_fifo_ctrl_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready;
  logic [5:0] count;
  logic       empty;
  logic       full;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, count, empty, full
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, count, empty, full
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// Byte FIFO controller over a single-port 32x8 RAM with registered read address;
// arbitrates pushes and head fetches onto the one port and holds the head in a register.
module ram_fifo_ctrl #(
  parameter int unsigned DEPTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  ram_fifo_ctrl_if.slave  fifo,
  output logic [5:0]      ram_address,
  output logic            ram_write_enable,
  output logic [7:0]      ram_data_in,
  input  logic [7:0]      ram_data_out
);

  logic [4:0] wr_ptr;
  logic [4:0] rd_ptr;
  logic [5:0] ram_cnt;
  logic [5:0] count_q;
  logic       pend;
  logic       prio;
  logic       out_valid;
  logic [7:0] out_data;

  logic not_full;
  logic push_req;
  logic fetch_req;
  logic grant_w;
  logic grant_f;
  logic pop;

  always_comb begin
    not_full  = count_q < 6'(DEPTH);
    push_req  = fifo.wr_valid && not_full;
    fetch_req = (ram_cnt != '0) && !pend && (!out_valid || fifo.rd_ready);
    // Gating with rst keeps the RAM write pin and wr_ready low throughout reset.
    grant_w   = !rst && push_req && (!fetch_req || !prio);
    grant_f   = fetch_req && (!push_req || prio);
    pop       = out_valid && fifo.rd_ready;
  end

  assign fifo.wr_ready  = !rst && not_full && !(fetch_req && prio);
  assign fifo.rd_valid  = out_valid;
  assign fifo.rd_data   = out_data;
  assign fifo.count     = count_q;
  assign fifo.empty     = (count_q == '0);
  assign fifo.full      = (count_q == 6'(DEPTH));

  assign ram_write_enable = grant_w;
  assign ram_address      = {1'b0, grant_w ? wr_ptr : rd_ptr};
  assign ram_data_in      = fifo.wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      count_q   <= '0;
      pend      <= 1'b0;
      prio      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (grant_w) wr_ptr <= wr_ptr + 5'd1;
      if (grant_f) rd_ptr <= rd_ptr + 5'd1;
      ram_cnt <= ram_cnt + {5'b0, grant_w} - {5'b0, grant_f};
      count_q <= count_q + {5'b0, grant_w} - {5'b0, pop};
      pend    <= grant_f;
      if (push_req && fetch_req) prio <= ~prio;
      // A capture landing on a pop edge replaces the popped head.
      if (pend) begin
        out_data  <= ram_data_out;
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural registered-address RAM.
module tb_ram_fifo_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_fifo_ctrl_if fi();

  logic [5:0] ram_address;
  logic       ram_write_enable;
  logic [7:0] ram_data_in;
  logic [7:0] ram_data_out;

  ram_fifo_ctrl #(.DEPTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .fifo             (fi),
    .ram_address      (ram_address),
    .ram_write_enable (ram_write_enable),
    .ram_data_in      (ram_data_in),
    .ram_data_out     (ram_data_out)
  );

  logic [7:0] mem [0:63];
  logic [5:0] addr_q = '0;
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_address] <= ram_data_in;
    else                  addr_q <= ram_address;
  end
  assign ram_data_out = mem[addr_q];

  logic msb_seen = 1'b0;
  always @(posedge clk) if (ram_address[5]) msb_seen <= 1'b1;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb [$];

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       rr;
    logic       rv;
    logic [7:0] rdat;
    logic [5:0] cnt;
    logic       wrdy;
    logic       we;
  } vec_t;
  vec_t vt [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    bit ok = 0;
    fi.wr_valid = 1'b1;
    fi.wr_data  = b;
    for (int k = 0; k < 20 && !ok; k++) begin
      #1;
      if (fi.wr_ready) ok = 1;
      @(posedge clk);
      @(negedge clk);
    end
    fi.wr_valid = 1'b0;
    chk("push_accept", ok, 1);
    if (ok) sb.push_back(b);
  endtask

  task automatic pop_chk(input string name);
    bit ok = 0;
    logic [7:0] e;
    fi.rd_ready = 1'b1;
    for (int k = 0; k < 10 && !ok; k++) begin
      #1;
      if (fi.rd_valid) begin
        ok = 1;
        e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        chk(name, fi.rd_data, e);
      end
      @(posedge clk);
      @(negedge clk);
    end
    fi.rd_ready = 1'b0;
    chk({name, "_timeout"}, ok, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic       prev_low;
    int         nf;
    int         last;
    bit         acc;

    vt[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 6'd0, 1'b1, 1'b1};
    vt[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 6'd1, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 6'd1, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 6'd1, 1'b1, 1'b1};
    vt[4]  = '{1'b1, 8'h5A, 1'b0, 1'b1, 8'hA5, 6'd2, 1'b1, 1'b1};
    vt[5]  = '{1'b1, 8'h77, 1'b1, 1'b1, 8'hA5, 6'd3, 1'b1, 1'b1};
    vt[6]  = '{1'b1, 8'h88, 1'b1, 1'b0, 8'h00, 6'd3, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 8'h88, 1'b1, 1'b0, 8'h00, 6'd3, 1'b1, 1'b1};
    vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h3C, 6'd4, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 6'd3, 1'b1, 1'b0};
    vt[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 6'd3, 1'b1, 1'b0};

    // Reset values, with wr_valid high to show wr_ready stays low in reset.
    fi.wr_valid = 1'b1;
    fi.wr_data  = 8'h00;
    fi.rd_ready = 1'b0;
    #1;
    chk("rst_rd_valid", fi.rd_valid, 0);
    chk("rst_count", fi.count, 0);
    chk("rst_empty", fi.empty, 1);
    chk("rst_full", fi.full, 0);
    chk("rst_wr_ready", fi.wr_ready, 0);
    chk("rst_we", ram_write_enable, 0);
    @(negedge clk);
    rst = 1'b0;
    fi.wr_valid = 1'b0;

    // Reset asserted while a fetch is pending.
    push(8'h11);
    push(8'h22);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_rd_valid", fi.rd_valid, 0);
    chk("midrst_count", fi.count, 0);
    chk("midrst_empty", fi.empty, 1);
    chk("midrst_wr_ready", fi.wr_ready, 0);
    chk("midrst_we", ram_write_enable, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;

    // Cycle-by-cycle vectors from a clean state.
    for (int i = 0; i < 11; i++) begin
      fi.wr_valid = vt[i].wv;
      fi.wr_data  = vt[i].wd;
      fi.rd_ready = vt[i].rr;
      #1;
      chk($sformatf("vec%0d_rd_valid", i), fi.rd_valid, vt[i].rv);
      if (vt[i].rv) chk($sformatf("vec%0d_rd_data", i), fi.rd_data, vt[i].rdat);
      chk($sformatf("vec%0d_count", i), fi.count, vt[i].cnt);
      chk($sformatf("vec%0d_wr_ready", i), fi.wr_ready, vt[i].wrdy);
      chk($sformatf("vec%0d_we", i), ram_write_enable, vt[i].we);
      @(posedge clk);
      @(negedge clk);
    end
    fi.wr_valid = 1'b0;
    fi.rd_ready = 1'b0;

    // Fill to 32 and try a 33rd push.
    do_reset();
    for (int i = 0; i < 32; i++) push(8'(i));
    #1;
    chk("fill_count", fi.count, 32);
    chk("fill_full", fi.full, 1);
    chk("fill_wr_ready", fi.wr_ready, 0);
    @(negedge clk);
    fi.wr_valid = 1'b1;
    fi.wr_data  = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("push33_wr_ready", fi.wr_ready, 0);
      chk("push33_we", ram_write_enable, 0);
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk("push33_count", fi.count, 32);

    // Simultaneous push and pop at full.
    @(negedge clk);
    fi.rd_ready = 1'b1;
    fi.wr_data  = 8'h55;
    #1;
    chk("fullpp_wr_ready", fi.wr_ready, 0);
    chk("fullpp_rd_valid", fi.rd_valid, 1);
    chk("fullpp_rd_data", fi.rd_data, sb.pop_front());
    @(posedge clk);
    @(negedge clk);
    fi.wr_valid = 1'b0;
    #1;
    chk("fullpp_count", fi.count, 31);
    chk("fullpp_wr_ready_next", fi.wr_ready, 1);

    // Drain: in order, one pop every 2 cycles.
    last = -1;
    for (int c = 0; c < 150 && sb.size() > 0; c++) begin
      if (fi.rd_valid) begin
        chk("drain_data", fi.rd_data, sb.pop_front());
        if (last >= 0) chk("drain_interval", c - last, 2);
        last = c;
      end
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    chk("drain_all", sb.size(), 0);
    chk("drain_count", fi.count, 0);
    chk("drain_empty", fi.empty, 1);
    chk("drain_rd_valid", fi.rd_valid, 0);
    fi.rd_ready = 1'b0;
    @(negedge clk);

    // Pointer wrap across three rounds.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 20; i++) push(8'(8'h40 + r * 20 + i));
      for (int i = 0; i < 20; i++) pop_chk("wrap_data");
    end
    #1;
    chk("wrap_count", fi.count, 0);
    @(negedge clk);

    // Conflict: writes and fetches interleave, nothing lost.
    push(8'h90);
    push(8'h91);
    push(8'h92);
    d = 8'hA0;
    prev_low = 1'b0;
    nf = 0;
    fi.wr_valid = 1'b1;
    fi.rd_ready = 1'b1;
    fi.wr_data  = d;
    for (int c = 0; c < 18; c++) begin
      #1;
      chk("conflict_we_accept", ram_write_enable, fi.wr_ready);
      chk("conflict_no_double_idle", prev_low & ~ram_write_enable, 0);
      prev_low = ~ram_write_enable;
      if (!ram_write_enable) nf++;
      acc = fi.wr_ready;
      if (acc) sb.push_back(d);
      if (fi.rd_valid) chk("conflict_data", fi.rd_data, (sb.size() > 0) ? sb.pop_front() : 8'hxx);
      @(posedge clk);
      @(negedge clk);
      if (acc) d = d + 8'd1;
      fi.wr_data = d;
    end
    fi.wr_valid = 1'b0;
    fi.rd_ready = 1'b0;
    chk("conflict_fetches", nf >= 5, 1);
    for (int k = 0; k < 40 && sb.size() > 0; k++) pop_chk("conflict_drain");
    chk("conflict_all", sb.size(), 0);
    #1;
    chk("conflict_count", fi.count, 0);
    chk("conflict_empty", fi.empty, 1);

    chk("addr_msb_never_set", msb_seen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
